// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a bounded hold time.
// The owner index and busy flag are registered; the one-hot grant bus is a
// plain 2-to-4 decode of them, so no output depends combinationally on req.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 4  // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hcnt value before the owner must give way to a waiting requester.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [7:0] hcnt;

    logic       owner_req;
    logic [3:0] others;
    logic       any_req;
    logic       any_other;
    logic [1:0] win_all;
    logic [1:0] win_other;

    // First set bit of mask scanning start, start+1, ... (mod 4).
    // Scanning backwards and overwriting leaves the earliest hit in result.
    function automatic logic [1:0] rr_search(input logic [3:0] mask,
                                             input logic [1:0] start);
        logic [1:0] result;
        logic [1:0] cand;
        result = start;
        for (int i = 3; i >= 0; i--) begin
            cand = start + 2'(i);
            if (mask[cand]) result = cand;
        end
        return result;
    endfunction

    // Arbitration candidates derived from the current request vector.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        owner_req = req[owner];
        others    = req & ~(4'b0001 << owner);
        any_req   = |req;
        any_other = |others;
        win_all   = rr_search(req, ptr);
        win_other = rr_search(others, ptr);
    end

    // Owner/busy/pointer/hold-counter state machine; reset overrides all.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // right-hand side sees the values from before this edge.
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
            hcnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= GRANT;
                        owner <= win_all;
                        ptr   <= win_all + 2'd1;
                        hcnt  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (owner_req && !any_other) begin
                        // Sole requester: keep the grant, counter saturates.
                        if (hcnt < HOLD_LAST) hcnt <= hcnt + 8'd1;
                    end else if (owner_req && hcnt < HOLD_LAST) begin
                        // Others waiting but hold budget not yet used up.
                        hcnt <= hcnt + 8'd1;
                    end else if (any_other) begin
                        // Forced rotation or release with a waiter: the owner
                        // is excluded either way, so both resolve identically.
                        owner <= win_other;
                        ptr   <= win_other + 2'd1;
                        hcnt  <= 8'd0;
                    end else begin
                        state <= IDLE;
                        hcnt  <= 8'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= 8'd0;
                end
            endcase
        end
    end

    // Grant bus: 2-to-4 decode of the registered owner, gated by busy.
    always_comb begin
        gnt_valid = (state == GRANT);
        gnt_idx   = owner;
        gnt       = gnt_valid ? (4'b0001 << owner) : 4'b0000;
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed vectors for two arbiter instances (MAX_HOLD=4 and
// MAX_HOLD=1). The stimulus process queues the expected grant for each cycle;
// an independent monitor pops and compares after every rising edge.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = 4'b0000;
    logic [3:0] req1 = 4'b0000;

    logic [3:0] gnt4, gnt1;
    logic [1:0] idx4, idx1;
    logic       vld4, vld1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         sel1;     // 1: compare against the MAX_HOLD=1 instance
        logic [3:0] gnt;
        logic [1:0] idx;
        bit         chk_idx;  // compare idx even when no grant is expected
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4)
    );

    rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1)
    );

    task automatic check(input string name, input logic [7:0] actual,
                         input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the grant must be after the edge.
    task automatic step(input logic [3:0] r4, input logic [3:0] r1,
                        input logic rst_v, input bit sel1,
                        input logic [3:0] g, input logic [1:0] idx,
                        input bit chk_idx, input string tag);
        exp_t e;
        @(negedge clk);
        req4 = r4;
        req1 = r1;
        rst  = rst_v;
        e.sel1 = sel1; e.gnt = g; e.idx = idx; e.chk_idx = chk_idx; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: invariants on both instances every cycle, plus queued checks.
    initial begin
        exp_t e;
        logic [3:0] g;
        logic [1:0] ix;
        logic       v;
        forever begin
            @(posedge clk);
            #2;
            check("onehot_h4", 8'($onehot0(gnt4)), 8'd1);
            check("valid_or_h4", 8'(vld4), 8'(|gnt4));
            check("onehot_h1", 8'($onehot0(gnt1)), 8'd1);
            check("valid_or_h1", 8'(vld1), 8'(|gnt1));
            if (vld4) check("decode_h4", 8'(gnt4), 8'(4'b0001 << idx4));
            if (vld1) check("decode_h1", 8'(gnt1), 8'(4'b0001 << idx1));
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                g  = e.sel1 ? gnt1 : gnt4;
                ix = e.sel1 ? idx1 : idx4;
                v  = e.sel1 ? vld1 : vld4;
                check({e.tag, "_gnt"}, 8'(g), 8'(e.gnt));
                check({e.tag, "_valid"}, 8'(v), 8'(|e.gnt));
                if (e.chk_idx || (|e.gnt)) check({e.tag, "_idx"}, 8'(ix), 8'(e.idx));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state on both instances.
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, "reset_h4");
        step(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1, "reset_h1");

        // Sole requester 2 holds indefinitely, no rotation.
        for (int i = 0; i < 20; i++)
            step(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0, "sole_hold");

        // Reset while owner 2 is granted; then ptr restarts at 0.
        step(4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, "reset_mid");

        // All four requesting: owners 0,1,2,3,0 each for exactly 4 cycles.
        for (int i = 0; i < 20; i++) begin
            logic [1:0] o;
            o = 2'((i / 4) % 4);
            step(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001 << o, o, 1'b0, "round_robin");
        end

        // Release handoff 0 -> 1 without a gap, then release to idle.
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, "reset_rel");
        step(4'b0011, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, "rel_owner0");
        step(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, "rel_handoff");
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, "rel_idle");

        // Owner 3 with requester 0 waiting: forced rotation wraps to 0,
        // then owner 0 releases and 3 gets the grant back.
        step(4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0, "ptr_owner3");
        for (int i = 0; i < 3; i++)
            step(4'b1001, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0, "ptr_hold3");
        step(4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, "ptr_wrap0");
        step(4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0, "ptr_back3");
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, "ptr_idle");

        // MAX_HOLD=1: requesters 1 and 2 alternate every cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step(4'b0000, 4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, "hold1_alt");
            else
                step(4'b0000, 4'b0110, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, "hold1_alt");
        end
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, "hold1_idle");

        // Let the monitor drain the queue.
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
